// File: rtl/readout_sequencer.sv
// readout_sequencer: runs chip reset, trigger, data-ready wait, SPI readout command and sample
// counting for a programmed number of events, driving the trigger/readout block controls.
// Ports:
//   clk, rst                  readout clock (40 MHz), synchronous active-high reset
//   start, stop               run control pulses (start honoured only in IDLE)
//   num_events                events per run, 0 = run until stop
//   trig_from_chip            chip data-ready level, rising edge advances WAIT_TRIG
//   spi_cmd_done              SPI master finished the readout command
//   fifo_wr_en                ADC sample strobe, counted only in READOUT
//   chip_rst, trig_to_chip    chip reset / trigger pulses
//   spi_cmd_req               level request to the SPI master
//   spi_readout_ready         one-cycle pulse that starts chip read clocking
//   busy, events_done         run status and saturating completed-event count
//   timeout_err, state_o      sticky timeout flag and state encoding for status
module readout_sequencer #(
  parameter int NUM_DATA          = 1280,
  parameter int RST_PULSE_LEN     = 8,
  parameter int TRIG_PULSE_LEN    = 4,
  parameter int TIMEOUT_CYCLES    = 65535,
  parameter int EVENT_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [EVENT_COUNT_WIDTH-1:0] num_events,
  input  logic                         trig_from_chip,
  input  logic                         spi_cmd_done,
  input  logic                         fifo_wr_en,
  output logic                         chip_rst,
  output logic                         trig_to_chip,
  output logic                         spi_cmd_req,
  output logic                         spi_readout_ready,
  output logic                         busy,
  output logic [EVENT_COUNT_WIDTH-1:0] events_done,
  output logic                         timeout_err,
  output logic [2:0]                   state_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_CHIP_RST, S_TRIG, S_WAIT_TRIG, S_SPI_CMD, S_READOUT, S_DONE
  } state_t;
  localparam int MAXC = TIMEOUT_CYCLES > RST_PULSE_LEN
                        ? (TIMEOUT_CYCLES > TRIG_PULSE_LEN ? TIMEOUT_CYCLES : TRIG_PULSE_LEN)
                        : (RST_PULSE_LEN > TRIG_PULSE_LEN ? RST_PULSE_LEN : TRIG_PULSE_LEN);
  localparam int CW = $clog2(MAXC + 1);
  localparam int SW = $clog2(NUM_DATA + 1);
  localparam int EW = EVENT_COUNT_WIDTH;
  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [SW-1:0]  r_samp;
  logic [EW-1:0]  r_num, r_events;
  logic           r_tout, r_stop_pend, r_trig_d, r_rdy;
  logic           w_edge, w_tmo, w_last, w_tmo_set, w_inc, w_final;
  logic [EW:0]    w_ev_plus;
  assign w_edge    = trig_from_chip & ~r_trig_d;
  assign w_tmo     = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_last    = fifo_wr_en && r_samp == SW'(NUM_DATA - 1);
  assign w_ev_plus = {1'b0, r_events} + 1'b1;
  // unsaturated compare so a run of exactly all-ones events still terminates
  assign w_final   = (r_num != '0 && w_ev_plus == {1'b0, r_num}) || r_stop_pend || stop;
  // completion conditions are tested before the timeout so they win a same-cycle tie
  always_comb begin
    w_next    = r_state;
    w_tmo_set = 1'b0;
    w_inc     = 1'b0;
    case (r_state)
      S_IDLE:      w_next = start ? S_CHIP_RST : S_IDLE;
      S_CHIP_RST:  w_next = r_cnt == CW'(RST_PULSE_LEN - 1) ? S_TRIG : S_CHIP_RST;
      S_TRIG:      w_next = r_cnt == CW'(TRIG_PULSE_LEN - 1) ? S_WAIT_TRIG : S_TRIG;
      S_WAIT_TRIG: begin
        w_next    = (stop || r_stop_pend || w_tmo) ? S_DONE : w_edge ? S_SPI_CMD : S_WAIT_TRIG;
        w_next    = (w_edge && !stop && !r_stop_pend) ? S_SPI_CMD : w_next;
        w_tmo_set = w_tmo && !w_edge && !stop && !r_stop_pend;
      end
      S_SPI_CMD: begin
        w_next    = spi_cmd_done ? S_READOUT : w_tmo ? S_DONE : S_SPI_CMD;
        w_tmo_set = w_tmo && !spi_cmd_done;
      end
      S_READOUT: begin
        w_inc     = w_last;
        w_next    = w_last ? (w_final ? S_DONE : S_TRIG) : w_tmo ? S_DONE : S_READOUT;
        w_tmo_set = w_tmo && !w_last;
      end
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_samp      <= '0;
      r_num       <= '0;
      r_events    <= '0;
      r_tout      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_trig_d    <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_trig_d <= trig_from_chip;
      // one counter times the pulses and the timeout; it restarts on every state change
      r_cnt    <= (w_next != r_state || r_state == S_IDLE || r_state == S_DONE) ? '0 : r_cnt + 1'b1;
      r_samp   <= (r_state == S_READOUT && w_next == S_READOUT) ? r_samp + SW'(fifo_wr_en) : '0;
      r_rdy    <= r_state == S_SPI_CMD && w_next == S_READOUT;
      if (r_state == S_IDLE && start) begin
        r_num       <= num_events;
        r_events    <= '0;
        r_tout      <= 1'b0;
        r_stop_pend <= 1'b0;
      end else begin
        if (w_tmo_set) r_tout <= 1'b1;
        if (w_inc && !(&r_events)) r_events <= r_events + 1'b1;
        if (stop && r_state != S_IDLE && r_state != S_DONE) r_stop_pend <= 1'b1;
      end
    end
  end
  assign chip_rst          = r_state == S_CHIP_RST;
  assign trig_to_chip      = r_state == S_TRIG;
  assign spi_cmd_req       = r_state == S_SPI_CMD;
  assign spi_readout_ready = r_rdy;
  assign busy              = r_state != S_IDLE;
  assign events_done       = r_events;
  assign timeout_err       = r_tout;
  assign state_o           = r_state;
endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: directed bench for readout_sequencer with a small chip/SPI responder.
// u_dut uses the default parameters; u_to uses TIMEOUT_CYCLES=100 for the timeout cases.
module tb_readout_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start = 0, stop = 0, trig_from_chip = 0, spi_cmd_done = 0, fifo_wr_en = 0;
  logic [15:0] num_events = '0;
  logic chip_rst, trig_to_chip, spi_cmd_req, spi_readout_ready, busy, timeout_err;
  logic [15:0] events_done;
  logic [2:0] state_o;
  logic t_start = 0, t_stop = 0, t_trig = 0, t_done = 0, t_fifo = 0;
  logic [15:0] t_num = 16'd1;
  logic t_chip_rst, t_trig_o, t_req, t_rdy, t_busy, t_tout;
  logic [15:0] t_events;
  logic [2:0] t_state;
  readout_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_events(num_events),
    .trig_from_chip(trig_from_chip), .spi_cmd_done(spi_cmd_done), .fifo_wr_en(fifo_wr_en),
    .chip_rst(chip_rst), .trig_to_chip(trig_to_chip), .spi_cmd_req(spi_cmd_req),
    .spi_readout_ready(spi_readout_ready), .busy(busy), .events_done(events_done),
    .timeout_err(timeout_err), .state_o(state_o)
  );
  readout_sequencer #(.NUM_DATA(16), .TIMEOUT_CYCLES(100)) u_to (
    .clk(clk), .rst(rst), .start(t_start), .stop(t_stop), .num_events(t_num),
    .trig_from_chip(t_trig), .spi_cmd_done(t_done), .fifo_wr_en(t_fifo),
    .chip_rst(t_chip_rst), .trig_to_chip(t_trig_o), .spi_cmd_req(t_req),
    .spi_readout_ready(t_rdy), .busy(t_busy), .events_done(t_events),
    .timeout_err(t_tout), .state_o(t_state)
  );
  int n_chk = 0, n_err = 0, cyc = 0;
  int n_rst_hi, n_rst_pulse, n_trig, n_trig_hi, n_rdy, n_bad, n_ro_hi, last_done, td, sd, fifo_mode, c0;
  bit auto_chip, spi_auto;
  logic p_rst, p_trig, p_req, last_ro_fifo;
  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic clear();
    n_rst_hi = 0; n_rst_pulse = 0; n_trig = 0; n_trig_hi = 0;
    n_rdy = 0; n_bad = 0; n_ro_hi = 0; last_done = -100; last_ro_fifo = 0;
  endtask
  // one clock; observe outputs, then drive the chip/SPI/fifo responses for the next cycle
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (chip_rst) n_rst_hi++;
    if (chip_rst && !p_rst) n_rst_pulse++;
    if (trig_to_chip) n_trig_hi++;
    if (trig_to_chip && !p_trig) n_trig++;
    if (spi_readout_ready) n_rdy++;
    if (spi_readout_ready && (spi_cmd_req || state_o != 3'd5)) n_bad++;
    if (state_o == 3'd6) last_done = cyc;
    if (auto_chip) begin
      trig_from_chip = 0;
      if (td > 0) begin
        td--;
        if (td == 0) trig_from_chip = 1;
      end
      if (p_trig && !trig_to_chip) td = 50;
    end else td = 0;
    spi_cmd_done = 0;
    if (spi_auto) begin
      if (sd > 0) begin
        sd--;
        if (sd == 0) spi_cmd_done = 1;
      end
      if (spi_cmd_req && !p_req) sd = 20;
    end else sd = 0;
    fifo_wr_en = fifo_mode == 1 ? 1'b1 : fifo_mode == 2 ? cyc[0] : 1'b0;
    if (state_o == 3'd5) begin
      if (fifo_wr_en) n_ro_hi++;
      last_ro_fifo = fifo_wr_en;
    end
    p_rst = chip_rst; p_trig = trig_to_chip; p_req = spi_cmd_req;
  endtask
  task automatic wait_state(input string tag, input int s, input int lim);
    for (int i = 0; i < lim && int'(state_o) != s; i++) tick();
    check(tag, state_o, s);
  endtask
  task automatic do_start(input int n);
    num_events = 16'(n);
    start = 1;
    tick();
    start = 0;
  endtask
  initial begin
    clear();
    auto_chip = 1; spi_auto = 1; fifo_mode = 0; td = 0; sd = 0;
    p_rst = 0; p_trig = 0; p_req = 0;
    repeat (3) tick();
    check("rst_state", state_o, 0);
    check("rst_outs", {chip_rst, trig_to_chip, spi_cmd_req, spi_readout_ready, busy, timeout_err}, 0);
    check("rst_events", events_done, 0);
    check("rst_to_state", t_state, 0);
    rst = 0;
    tick();
    // two events, continuous samples
    clear(); fifo_mode = 1;
    do_start(2);
    wait_state("run2_idle", 0, 6000);
    check("run2_rst_cycles", n_rst_hi, 8);
    check("run2_rst_pulses", n_rst_pulse, 1);
    check("run2_trig_pulses", n_trig, 2);
    check("run2_trig_cycles", n_trig_hi, 8);
    check("run2_rdy_pulses", n_rdy, 2);
    check("run2_rdy_shape", n_bad, 0);
    check("run2_samples", n_ro_hi, 2560);
    check("run2_events", events_done, 2);
    check("run2_busy_drop", cyc - last_done, 1);
    check("run2_tout", timeout_err, 0);
    repeat (10) tick();
    check("idle_fifo_events", events_done, 2);
    // timeout in WAIT_TRIG
    t_start = 1; tick(); t_start = 0;
    for (int i = 0; i < 50 && t_state != 3'd3; i++) tick();
    check("to_enter_wait", t_state, 3);
    c0 = cyc;
    for (int i = 0; i < 200 && !t_tout; i++) tick();
    check("to_latency", cyc - c0, 100);
    check("to_state_done", t_state, 6);
    check("to_events", t_events, 0);
    tick();
    check("to_idle", t_state, 0);
    check("to_sticky", t_tout, 1);
    // timeout in SPI_CMD drops the request
    t_start = 1; tick(); t_start = 0;
    check("to2_cleared", t_tout, 0);
    for (int i = 0; i < 50 && t_state != 3'd3; i++) tick();
    t_trig = 1; tick(); t_trig = 0;
    check("to2_spi", t_state, 4);
    check("to2_req", t_req, 1);
    for (int i = 0; i < 200 && !t_tout; i++) tick();
    check("to2_tout", t_tout, 1);
    check("to2_req_drop", t_req, 0);
    check("to2_events", t_events, 0);
    // continuous mode, stop during the third readout
    clear();
    do_start(0);
    for (int i = 0; i < 8000 && !(n_rdy == 3 && state_o == 3'd5); i++) tick();
    check("cont_reach_ev3", n_rdy, 3);
    repeat (100) tick();
    stop = 1; tick(); stop = 0;
    wait_state("cont_idle", 0, 3000);
    check("cont_events", events_done, 3);
    check("cont_trigs", n_trig, 3);
    check("cont_samples", n_ro_hi, 3840);
    check("cont_tout", timeout_err, 0);
    // 50% duty samples, start and stop together in IDLE
    clear(); fifo_mode = 2;
    num_events = 16'd2; start = 1; stop = 1; tick(); start = 0; stop = 0;
    wait_state("duty_idle", 0, 9000);
    check("duty_events", events_done, 2);
    check("duty_trigs", n_trig, 2);
    check("duty_samples", n_ro_hi, 2560);
    check("duty_last_hi", last_ro_fifo, 1);
    repeat (20) tick();
    check("duty_idle_events", events_done, 2);
    // reset while the SPI request is up
    clear(); fifo_mode = 1; spi_auto = 0;
    do_start(1);
    wait_state("rst_spi_reach", 4, 500);
    check("rst_spi_req", spi_cmd_req, 1);
    rst = 1; tick();
    check("rst_mid_state", state_o, 0);
    check("rst_mid_outs", {chip_rst, trig_to_chip, spi_cmd_req, spi_readout_ready, busy, timeout_err}, 0);
    rst = 0; spi_auto = 1; clear();
    tick();
    do_start(1);
    wait_state("rerun_idle", 0, 3000);
    check("rerun_rst_cycles", n_rst_hi, 8);
    check("rerun_rdy", n_rdy, 1);
    check("rerun_events", events_done, 1);
    // data-ready already high on entry to WAIT_TRIG
    clear(); auto_chip = 0; trig_from_chip = 1;
    do_start(1);
    wait_state("hi_reach_wait", 3, 100);
    repeat (30) tick();
    check("hi_hold", state_o, 3);
    trig_from_chip = 0;
    repeat (5) tick();
    check("hi_low", state_o, 3);
    trig_from_chip = 1; tick();
    check("hi_edge", state_o, 4);
    trig_from_chip = 0; auto_chip = 1;
    wait_state("hi_idle", 0, 3000);
    check("hi_events", events_done, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
